// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the sram22 BIST controller.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } elem_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bit i describes element Mi: address direction (1 = up), read background, write background.
  localparam logic [5:0] ELEM_UP     = 6'b100111;
  localparam logic [5:0] ELEM_RD_POL = 6'b010100;
  localparam logic [5:0] ELEM_WR_POL = 6'b001010;

  function automatic logic elem_two_op(elem_e e);
    elem_two_op = (e != M0) && (e != M5);
  endfunction

  // M0 only writes, M5 only reads; the others read in phase 0 and write in phase 1.
  function automatic op_e elem_op(elem_e e, logic phase);
    case (e)
      M0:      elem_op = OP_WR;
      M5:      elem_op = OP_RD;
      default: elem_op = phase ? OP_WR : OP_RD;
    endcase
  endfunction

  function automatic elem_e elem_next(elem_e e);
    case (e)
      M0:      elem_next = M1;
      M1:      elem_next = M2;
      M2:      elem_next = M3;
      M3:      elem_next = M4;
      M4:      elem_next = M5;
      default: elem_next = M5;
    endcase
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter with load-to-start-address, step and terminal-count flag.
module sram_bist_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  load,
  input  logic                  load_up,
  input  logic                  step,
  input  logic                  up,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  tc_c
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_up ? '0 : ADDR_MAX;
    end else if (step) begin
      addr_d = up ? addr_q + ADDR_WIDTH'(1) : addr_q - ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr = addr_q;
  assign tc_c = up ? (addr_q == ADDR_MAX) : (addr_q == '0);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller for one sram22 macro; drives the SRAM port and records the first failure.
// Optional SRAM_BIST_FAIL_CNT_EN adds a saturating miscompare counter output fail_count.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned WMASK_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [2:0]             fail_elem,
  output logic [DATA_WIDTH-1:0]  fail_data,
`ifdef SRAM_BIST_FAIL_CNT_EN
  output logic [ADDR_WIDTH+2:0]  fail_count,
`endif
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  state_e state_q, state_d;
  elem_e  elem_q, elem_d;
  logic   phase_q, phase_d;
  logic   we_q, we_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic   busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  elem_e  fail_elem_q, fail_elem_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic   tag_valid_q, tag_valid_d;
  logic [DATA_WIDTH-1:0] tag_exp_q, tag_exp_d;
  logic [ADDR_WIDTH-1:0] tag_addr_q, tag_addr_d;
  elem_e  tag_elem_q, tag_elem_d;

  logic ag_load, ag_load_up, ag_step, ag_up, ag_tc_c;
  logic [ADDR_WIDTH-1:0] ag_addr;
  logic start_acc_c, last_op_c, miscmp_c;

  sram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk     (clk),
    .rstb    (rstb),
    .load    (ag_load),
    .load_up (ag_load_up),
    .step    (ag_step),
    .up      (ag_up),
    .addr    (ag_addr),
    .tc_c    (ag_tc_c)
  );

  assign ag_up       = ELEM_UP[elem_q];
  assign start_acc_c = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_op_c   = (state_q == RUN) && (elem_q == M5) && ag_tc_c;
  // Case-inequality so an X on dout is reported as a miscompare.
  assign miscmp_c    = tag_valid_q && (sram_dout !== tag_exp_q);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)     state_d = RUN;
      RUN:        if (last_op_c) state_d = DRAIN;
      DRAIN:                     state_d = DONE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    elem_d      = elem_q;
    phase_d     = phase_q;
    ag_load     = 1'b0;
    ag_load_up  = 1'b1;
    ag_step     = 1'b0;
    we_d        = 1'b0;
    din_d       = '0;
    busy_d      = (state_d == RUN) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
    tag_valid_d = (state_q == RUN) && (elem_op(elem_q, phase_q) == OP_RD);
    tag_exp_d   = {DATA_WIDTH{ELEM_RD_POL[elem_q]}};
    tag_addr_d  = ag_addr;
    tag_elem_d  = elem_q;

    // Sequence the next op: read then write on one address, then advance address or element.
    if (start_acc_c) begin
      elem_d  = M0;
      phase_d = 1'b0;
      ag_load = 1'b1;
    end else if ((state_q == RUN) && !last_op_c) begin
      if (elem_two_op(elem_q) && !phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (ag_tc_c) begin
          elem_d     = elem_next(elem_q);
          ag_load    = 1'b1;
          ag_load_up = ELEM_UP[elem_d];
        end else begin
          ag_step = 1'b1;
        end
      end
    end

    if (start_acc_c || ((state_q == RUN) && !last_op_c)) begin
      we_d  = (elem_op(elem_d, phase_d) == OP_WR);
      din_d = we_d ? {DATA_WIDTH{ELEM_WR_POL[elem_d]}} : '0;
    end

    if (start_acc_c) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = M0;
      fail_data_d = '0;
    end else if (miscmp_c) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = tag_addr_q;
        fail_elem_d = tag_elem_q;
        fail_data_d = sram_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      elem_q      <= M0;
      phase_q     <= 1'b0;
      we_q        <= 1'b0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= M0;
      fail_data_q <= '0;
      tag_valid_q <= 1'b0;
      tag_exp_q   <= '0;
      tag_addr_q  <= '0;
      tag_elem_q  <= M0;
    end else begin
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      we_q        <= we_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
      tag_valid_q <= tag_valid_d;
      tag_exp_q   <= tag_exp_d;
      tag_addr_q  <= tag_addr_d;
      tag_elem_q  <= tag_elem_d;
    end
  end

`ifdef SRAM_BIST_FAIL_CNT_EN
  localparam int unsigned CNT_W = ADDR_WIDTH + 3;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  // Saturating count of every miscompare in the run.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (start_acc_c)                          fail_cnt_d = '0;
    else if (miscmp_c && (fail_cnt_q != '1))  fail_cnt_d = fail_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) fail_cnt_q <= '0;
    else       fail_cnt_q <= fail_cnt_d;
  end

  assign fail_count = fail_cnt_q;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_addr  = fail_addr_q;
  assign fail_elem  = fail_elem_q;
  assign fail_data  = fail_data_q;
  assign sram_we    = we_q;
  assign sram_wmask = '1;
  assign sram_addr  = ag_addr;
  assign sram_din   = din_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist against a 64x4 behavioural SRAM with an optional stuck-at bit.
module tb_sram_march_bist;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 4;
  localparam int unsigned MW = 2;

  logic          clk   = 1'b0;
  logic          rstb  = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;
`ifdef SRAM_BIST_FAIL_CNT_EN
  logic [AW+2:0] fail_count;
`endif
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          stuck_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem),
    .fail_data  (fail_data),
`ifdef SRAM_BIST_FAIL_CNT_EN
    .fail_count (fail_count),
`endif
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: bit 2 of address 17 reads back as 1 while stuck_en is set.
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    else         sram_dout <= mem[sram_addr] | ((stuck_en && sram_addr == 6'd17) ? 4'b0100 : 4'b0000);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_fail"},  32'(fail), 32'd0);
    check({tag, "_faddr"}, 32'(fail_addr), 32'd0);
    check({tag, "_felem"}, 32'(fail_elem), 32'd0);
    check({tag, "_fdata"}, 32'(fail_data), 32'd0);
    check({tag, "_we"},    32'(sram_we), 32'd0);
    check({tag, "_addr"},  32'(sram_addr), 32'd0);
    check({tag, "_din"},   32'(sram_din), 32'd0);
    check({tag, "_wmask"}, 32'(sram_wmask), 32'h3);
  endtask

  // Start a run; edges counts clock edges after the accepting edge, sampled 1ns after each edge.
  task automatic run_bist(input int restart_at, input int reset_at, input bit mon, output int edges);
    int wr_cnt;
    logic [AW-1:0] exp_addr;
    logic exp_we;
    int j;
    wr_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edges = 0;
    check("accept_busy",  32'(busy), 32'd1);
    check("accept_done",  32'(done), 32'd0);
    check("accept_fail",  32'({fail, fail_addr, fail_elem, fail_data}), 32'd0);
    check("first_op",     32'({sram_we, sram_addr, sram_din}), 32'({1'b1, 6'd0, 4'h0}));
    forever begin
      if (edges == reset_at) begin
        rstb = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk); rstb = 1'b1;
        return;
      end
      if (mon && edges >= 320 && edges < 448) begin
        j        = edges - 320;
        exp_addr = 6'(63 - j / 2);
        exp_we   = (j % 2) == 1;
        check("m3_op", 32'({sram_we, sram_addr, sram_din}),
              32'({exp_we, exp_addr, exp_we ? 4'hF : 4'h0}));
      end
      if (edges < 640 && sram_we) wr_cnt++;
      if (edges == 640) check("drain_state", 32'({busy, done, sram_we}), 32'b100);
      if (done || edges >= 1000) break;
      start = (edges == restart_at - 1);
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check("done_edge", 32'(edges), 32'd641);
    check("done_busy", 32'({busy, done, sram_we}), 32'b010);
    if (mon) check("write_count", 32'(wr_cnt), 32'd320);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    #23;
    check_reset_vals("reset");
    @(negedge clk); rstb = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_we", 32'({busy, done, sram_we}), 32'd0);

    run_bist(0, -1, 1'b1, edges);
    check("clean_fail", 32'(fail), 32'd0);
    @(negedge clk);
    check("done_hold", 32'({busy, done, sram_we}), 32'b010);

    run_bist(100, -1, 1'b0, edges);
    check("restart_ignored_fail", 32'(fail), 32'd0);

    stuck_en = 1'b1;
    run_bist(0, -1, 1'b0, edges);
    check("stuck_fail",  32'(fail), 32'd1);
    check("stuck_elem",  32'(fail_elem), 32'd1);
    check("stuck_addr",  32'(fail_addr), 32'd17);
    check("stuck_data",  32'(fail_data), 32'b0100);
`ifdef SRAM_BIST_FAIL_CNT_EN
    check("stuck_count", 32'(fail_count), 32'd3);
`endif

    stuck_en = 1'b0;
    run_bist(0, -1, 1'b0, edges);
    check("rerun_fail", 32'(fail), 32'd0);
`ifdef SRAM_BIST_FAIL_CNT_EN
    check("rerun_count", 32'(fail_count), 32'd0);
`endif

    run_bist(0, 300, 1'b0, edges);
    @(negedge clk);
    check_reset_vals("post_reset");
    run_bist(0, -1, 1'b0, edges);
    check("after_reset_fail", 32'(fail), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- March C- built-in self-test controller for one sram22 macro (default 64 words x 4 bits, 2-bit write mask).
- Owns the macro's we/wmask/addr/din port while running and checks dout against expected background.
- Reports pass/fail plus first-failure diagnostics to the BIST control/scan registers.
- Sits between the BIST register block and the SRAM wrapper mux.

Parameters:
- ADDR_WIDTH, 6, SRAM address bits; depth = 1<<ADDR_WIDTH.
- DATA_WIDTH, 4, SRAM word width.
- WMASK_WIDTH, 2, SRAM write-mask bits; always driven all-ones.

Ports:
- clk  in  1  clock; same clock as the SRAM.
- rstb  in  1  asynchronous active-low reset.
- start  in  1  begin test; sampled only in IDLE or DONE.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next accepted start.
- fail  out  1  at least one miscompare seen; sticky until next start.
- fail_addr  out  ADDR_WIDTH  address of first miscompare.
- fail_elem  out  3  March element index (0-5) of first miscompare.
- fail_data  out  DATA_WIDTH  dout value at first miscompare.
- sram_we  out  1  SRAM write enable.
- sram_wmask  out  WMASK_WIDTH  SRAM write mask.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_din  out  DATA_WIDTH  SRAM write data.
- sram_dout  in  DATA_WIDTH  SRAM read data; valid the cycle after a read is issued.

Behaviour:
- Reset:
  - State IDLE.
  - busy = done = fail = 0; fail_addr, fail_elem and fail_data = 0.
  - sram_we = 0, sram_addr = 0, sram_din = 0, sram_wmask = all ones.
- States and transitions:
  - IDLE -> RUN on start; DONE -> RUN on start.
  - RUN -> DRAIN after the last op; DRAIN -> DONE.
  - Start is ignored in RUN and DRAIN.
- Accepting start:
  - Clears done, fail and the fail_* registers.
  - Sets busy.
  - First op is driven in the cycle after the accepting edge.
- March elements (0 = all zeros, 1 = all ones):
  - M0 up (w0).
  - M1 up (r0, w1).
  - M2 up (r1, w0).
  - M3 down (r0, w1).
  - M4 down (r1, w0).
  - M5 up (r0).
- Op issue:
  - One SRAM op per cycle; read-then-write on the same address in consecutive cycles.
  - "Up" runs 0..2^ADDR_WIDTH-1; "down" runs from the max address to 0.
  - The address counter wraps to the element's start address on element change.
- Compare:
  - Registered read tag: valid, expected, addr, elem.
  - A read issued in cycle t is compared against sram_dout in cycle t+1, before the next edge.
  - This holds even if t+1 is a write, since dout goes X only after that edge.
- Failure capture:
  - On miscompare, fail <= 1.
  - fail_addr, fail_elem and fail_data are captured only if fail was 0 (first failure).
  - Testing continues to the end.
- Cycle count:
  - 640 op cycles at default size.
  - DRAIN covers the final M5 compare.
  - done = 1 and busy = 0 exactly 641 edges after the accepting edge.
- Outside RUN, sram_we = 0 (no spurious writes).
- Reset mid-test returns immediately to reset values; SRAM contents are undefined.
- Comparison uses case-inequality, so X on dout counts as a failure.

Optional Feature:
- Macro SRAM_BIST_FAIL_CNT_EN.
- Defined:
  - Adds output fail_count (ADDR_WIDTH+3 bits), which counts all miscompares and saturates at all-ones.
  - Cleared on reset and on accepted start.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sram_bist_pkg:
  - March element enum (M0..M5).
  - Op encoding (RD/WR).
  - Per-element direction and data-polarity constant tables.
  - State enum (IDLE/RUN/DRAIN/DONE).
- One sub-module: sram_bist_addr_gen, the up/down address counter with load, step and terminal-count flag.

Test Plan:
- Fault-free 64x4 behavioural SRAM, pulse start -> sram_we low between ops where required; done = 1 at edge 641, busy deasserts together with it; fail = 0.
- SRAM bit 2 of addr 17 stuck-at-1 -> fail = 1, fail_elem = 1, fail_addr = 17, fail_data = 4'b0100; with SRAM_BIST_FAIL_CNT_EN, fail_count = 3 (M1, M3, M5).
- Address-order monitor during M3 -> addresses 63, 63, 62, 62 ... 0, 0 with we pattern 0, 1 repeating; din = 4'hF on writes.
- Assert start again at cycle 100 of a run -> ignored; done still lands at edge 641 after the original start.
- Drop rstb at cycle 300 -> all outputs reach reset values asynchronously; a new start reruns a full 641-cycle test and passes.
- Second start from DONE after a failing run, fault removed -> fail and fail_* cleared on the accepting edge; run ends with fail = 0.
